// File: rtl/int_ctrl.sv
// Prioritised, non-nesting interrupt controller: edge-latched pending bits, fixed lowest-index priority.
// Latency: event to irq is 2 cycles. The CPU paces requests through the ack/ret handshake; there is no other backpressure.
module int_ctrl #(
  parameter int          NSRC       = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              confINT,
  input  logic [NSRC-1:0]          src,
  input  logic [NSRC-1:0]          clr_pend,
  input  logic                     int_ack,
  input  logic                     int_ret,
  output logic                     irq,
  output logic [$clog2(NSRC)-1:0]  int_id,
  output logic [15:0]              int_vector,
  output logic [NSRC-1:0]          pending,
  output logic                     in_service
);

  localparam int IDW = $clog2(NSRC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            irq_q, irq_d;
  logic [IDW-1:0]  int_id_q, int_id_d;
  logic [15:0]     int_vector_q, int_vector_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] src_q, src_d;

  logic [NSRC-1:0] src_rise;
  logic [NSRC-1:0] eligible;
  logic            any_elig;
  logic [IDW-1:0]  win_idx;
  logic [NSRC-1:0] win_mask;
  logic [NSRC-1:0] ack_clr;
  logic            cfg_unused;

  assign cfg_unused = ^confINT[14:NSRC];

  always_comb begin
    src_d    = src;
    src_rise = src & ~src_q;
    eligible = pending_q & confINT[NSRC-1:0] & {NSRC{confINT[15]}};
    any_elig = |eligible;

    // Scan downward so the lowest set index is the last one written.
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IDW'(i);
    end
    win_mask = any_elig ? (NSRC'(1) << win_idx) : '0;

    state_d      = state_q;
    irq_d        = irq_q;
    int_id_d     = int_id_q;
    int_vector_d = int_vector_q;
    ack_clr      = '0;

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          state_d = REQ;
          irq_d   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack && any_elig) begin
          int_id_d     = win_idx;
          int_vector_d = VEC_BASE + 16'(win_idx) * VEC_STRIDE;
          ack_clr      = win_mask;
          irq_d        = 1'b0;
          state_d      = SERVICE;
        end else if (!any_elig) begin
          // Covers both a spurious ack and the request vanishing under clear/mask.
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (int_ret) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A rising edge in the same cycle as a clear keeps the bit set.
    pending_d = (pending_q & ~(clr_pend | ack_clr)) | src_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      int_id_q     <= '0;
      int_vector_q <= VEC_BASE;
      pending_q    <= '0;
      src_q        <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      int_id_q     <= int_id_d;
      int_vector_q <= int_vector_d;
      pending_q    <= pending_d;
      src_q        <= src_d;
    end
  end

  assign irq        = irq_q;
  assign int_id     = int_id_q;
  assign int_vector = int_vector_q;
  assign pending    = pending_q;
  assign in_service = (state_q == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: stimulus queues expected output snapshots, a negedge monitor pops and compares them.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] confINT;
  logic [7:0]  src;
  logic [7:0]  clr_pend;
  logic        int_ack;
  logic        int_ret;
  logic        irq;
  logic [2:0]  int_id;
  logic [15:0] int_vector;
  logic [7:0]  pending;
  logic        in_service;

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .confINT    (confINT),
    .src        (src),
    .clr_pend   (clr_pend),
    .int_ack    (int_ack),
    .int_ret    (int_ret),
    .irq        (irq),
    .int_id     (int_id),
    .int_vector (int_vector),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        irq;
    logic [2:0]  id;
    logic [15:0] vec;
    logic [7:0]  pend;
    logic        svc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every snapshot is tied to the cycle it was queued in.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s: snapshot for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
      end else if (irq !== e.irq || int_id !== e.id || int_vector !== e.vec ||
                   pending !== e.pend || in_service !== e.svc) begin
        failures++;
        $display("FAIL %s: got irq=%b id=%0d vec=%h pend=%h svc=%b, want irq=%b id=%0d vec=%h pend=%h svc=%b",
                 e.name, irq, int_id, int_vector, pending, in_service,
                 e.irq, e.id, e.vec, e.pend, e.svc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic i, input logic [2:0] id,
                     input logic [15:0] v, input logic [7:0] p, input logic s);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.irq  = i;
    e.id   = id;
    e.vec  = v;
    e.pend = p;
    e.svc  = s;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; confINT = 16'h0000; src = 8'h00; clr_pend = 8'h00;
    int_ack = 1'b0; int_ret = 1'b0;
    tick(); chk("reset", 0, 0, 16'h0010, 8'h00, 0);
    rst = 1'b0;
    tick(); chk("post_reset_idle", 0, 0, 16'h0010, 8'h00, 0);

    // Single event on source 2
    confINT = 16'h8004;
    src = 8'h04; tick(); chk("single_pend", 0, 0, 16'h0010, 8'h04, 0);
    src = 8'h00; tick(); chk("single_irq", 1, 0, 16'h0010, 8'h04, 0);
    tick(); tick(); chk("single_hold_req", 1, 0, 16'h0010, 8'h04, 0);
    int_ack = 1'b1; tick(); chk("single_ack", 0, 2, 16'h0018, 8'h00, 1);
    int_ack = 1'b0; int_ret = 1'b1; tick(); chk("single_ret", 0, 2, 16'h0018, 8'h00, 0);
    int_ret = 1'b0; tick(); chk("single_idle", 0, 2, 16'h0018, 8'h00, 0);

    // Priority re-evaluated at ack time
    confINT = 16'h80FF;
    src = 8'h20; tick(); chk("prio_pend5", 0, 2, 16'h0018, 8'h20, 0);
    src = 8'h00; tick(); chk("prio_irq", 1, 2, 16'h0018, 8'h20, 0);
    src = 8'h02; tick(); chk("prio_pend1", 1, 2, 16'h0018, 8'h22, 0);
    src = 8'h00; int_ack = 1'b1; tick(); chk("prio_ack1", 0, 1, 16'h0014, 8'h20, 1);
    int_ack = 1'b0; int_ret = 1'b1; tick(); chk("prio_ret", 0, 1, 16'h0014, 8'h20, 0);
    int_ret = 1'b0; tick(); chk("prio_reirq", 1, 1, 16'h0014, 8'h20, 0);
    int_ack = 1'b1; tick(); chk("prio_ack5", 0, 5, 16'h0024, 8'h00, 1);
    int_ack = 1'b0; int_ret = 1'b1; tick(); chk("prio_ret5", 0, 5, 16'h0024, 8'h00, 0);
    int_ret = 1'b0;

    // Masking and clear before ack
    confINT = 16'h0003;
    src = 8'h01; tick(); chk("mask_pend", 0, 5, 16'h0024, 8'h01, 0);
    src = 8'h00; tick(); chk("mask_noirq", 0, 5, 16'h0024, 8'h01, 0);
    confINT = 16'h8003; tick(); chk("mask_enable_irq", 1, 5, 16'h0024, 8'h01, 0);
    clr_pend = 8'h01; tick(); chk("mask_clr", 1, 5, 16'h0024, 8'h00, 0);
    clr_pend = 8'h00; tick(); chk("mask_drop", 0, 5, 16'h0024, 8'h00, 0);

    // Set/clear collision, spurious ack, global mask in REQ
    confINT = 16'h80FF;
    src = 8'h08; clr_pend = 8'h08; tick(); chk("collide_set_wins", 0, 5, 16'h0024, 8'h08, 0);
    src = 8'h00; clr_pend = 8'h00; tick(); chk("collide_irq", 1, 5, 16'h0024, 8'h08, 0);
    confINT = 16'h00FF; int_ack = 1'b1; tick(); chk("spurious_ack", 0, 5, 16'h0024, 8'h08, 0);
    int_ack = 1'b0; confINT = 16'h80FF; tick(); chk("reenable_irq", 1, 5, 16'h0024, 8'h08, 0);
    confINT = 16'h00FF; tick(); chk("global_mask_drop", 0, 5, 16'h0024, 8'h08, 0);
    clr_pend = 8'h08; tick(); chk("clr_masked", 0, 5, 16'h0024, 8'h00, 0);
    clr_pend = 8'h00; confINT = 16'h80FF;
    int_ack = 1'b1; tick(); chk("idle_ack_ignored", 0, 5, 16'h0024, 8'h00, 0);
    int_ack = 1'b0;

    // No nesting during SERVICE
    src = 8'h01; tick(); chk("nest_pend0", 0, 5, 16'h0024, 8'h01, 0);
    src = 8'h00; tick(); chk("nest_irq", 1, 5, 16'h0024, 8'h01, 0);
    int_ack = 1'b1; tick(); chk("nest_ack0", 0, 0, 16'h0010, 8'h00, 1);
    int_ack = 1'b0; src = 8'h01; tick(); chk("nest_ev0", 0, 0, 16'h0010, 8'h01, 1);
    src = 8'h80; tick(); chk("nest_ev7", 0, 0, 16'h0010, 8'h81, 1);
    src = 8'h00; int_ack = 1'b1; tick(); chk("svc_ack_ignored", 0, 0, 16'h0010, 8'h81, 1);
    int_ack = 1'b0; tick(); chk("nest_hold", 0, 0, 16'h0010, 8'h81, 1);
    int_ret = 1'b1; tick(); chk("nest_ret", 0, 0, 16'h0010, 8'h81, 0);
    int_ret = 1'b0; tick(); chk("nest_reirq", 1, 0, 16'h0010, 8'h81, 0);
    int_ack = 1'b1; tick(); chk("nest_ack0b", 0, 0, 16'h0010, 8'h80, 1);
    int_ack = 1'b0; int_ret = 1'b1; tick(); chk("nest_ret2", 0, 0, 16'h0010, 8'h80, 0);
    int_ret = 1'b0; tick(); chk("nest_irq7", 1, 0, 16'h0010, 8'h80, 0);
    int_ack = 1'b1; tick(); chk("nest_ack7", 0, 7, 16'h002C, 8'h00, 1);
    int_ack = 1'b0;

    // Reset during SERVICE with src[4] held high and a ret in the reset cycle
    src = 8'h10; rst = 1'b1; int_ret = 1'b1; tick(); chk("reset_in_svc", 0, 0, 16'h0010, 8'h00, 0);
    rst = 1'b0; int_ret = 1'b0; tick(); chk("held_src_sets", 0, 0, 16'h0010, 8'h10, 0);
    tick(); chk("held_src_irq", 1, 0, 16'h0010, 8'h10, 0);
    tick();
    int_ack = 1'b1; tick(); chk("held_src_ack", 0, 4, 16'h0020, 8'h00, 1);
    int_ack = 1'b0; tick(); chk("held_src_no_reset", 0, 4, 16'h0020, 8'h00, 1);
    src = 8'h00; int_ret = 1'b1; tick(); chk("final_ret", 0, 4, 16'h0020, 8'h00, 0);
    int_ret = 1'b0;

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d snapshots never checked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller sitting directly downstream of the IO peripheral block. It consumes the `confINT` configuration word and the peripheral event lines: UART receive, UART/SPI done, and GPI edges. It latches rising-edge events into a pending register and presents one prioritised, registered interrupt request with a vector to the CPU. The CPU completes each request with an ack/return handshake, and interrupts do not nest.

## Interface
- `NSRC`, 8: number of interrupt sources; fixed at 8, matching `confINT[7:0]`.
- `VEC_BASE`, 16'h0010: vector address of source 0.
- `VEC_STRIDE`, 16'h0004: vector spacing per source index.

- `clk`  in  1  CPU clock; the single clock of the block.
- `rst`  in  1  reset; synchronous and active-high.
- `confINT`  in  16  bits [7:0] are the per-source enables; bit 15 is the global enable; bits [14:8] are ignored.
- `src`  in  8  raw event lines; each is synchronous to `clk` and rising-edge sensitive.
- `clr_pend`  in  8  write-1-to-clear strobe for pending bits; valid for one cycle.
- `int_ack`  in  1  CPU accepts the request; one-cycle pulse.
- `int_ret`  in  1  CPU return-from-interrupt; one-cycle pulse.
- `irq`  out  1  registered interrupt request to the CPU.
- `int_id`  out  3  index of the source being serviced.
- `int_vector`  out  16  `VEC_BASE + int_id*VEC_STRIDE`, registered.
- `pending`  out  8  current pending register, for memory-mapped readback.
- `in_service`  out  1  high while state is SERVICE.

## Operation
- Edge detect: `src_q <= src` each cycle. The pending bit i sets when `src[i] & ~src_q[i]`.
- Masking:
  - A source latches pending regardless of its enable.
  - `eligible = pending & confINT[7:0] & {8{confINT[15]}}`.
- Pending clear:
  - Bit i clears on `clr_pend[i]`, or on an ack that selects i.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Priority: the lowest index among `eligible` bits wins, fixed priority.
- FSM states:
  - IDLE:
    - If `eligible != 0`, go to REQ and drive `irq` to 1.
    - `int_ack` and `int_ret` are ignored.
  - REQ:
    - If `int_ack` arrives and `eligible != 0`:
      - Latch the winning index into `int_id`/`int_vector`.
      - Clear that pending bit.
      - Drive `irq` to 0 and go to SERVICE.
    - If `int_ack` arrives and `eligible == 0` (spurious ack), go to IDLE and leave `int_id`/`int_vector` unchanged.
    - If there is no ack and `eligible` becomes 0 (cleared or masked), drive `irq` to 0 and go to IDLE.
  - SERVICE:
    - `irq` stays 0 and new events keep accumulating in `pending`.
    - `int_ret` goes to IDLE.
    - `int_ack` is ignored.
- The winner is re-evaluated at ack time, not at request time, so a higher-priority event arriving during REQ is serviced first.
- Reset values:
  - `irq`=0, `int_id`=0, `int_vector`=`VEC_BASE`, `pending`=0, `in_service`=0, state IDLE.
  - `src_q` resets to 0, so a source already high at reset release sets pending.

## Timing
- Event to irq: `src` first sampled high at edge k sets pending after edge k. `irq` is high after edge k+1, a 2-cycle latency.
- Ack: `int_ack` sampled at edge m:
  - `irq` is low after edge m.
  - `int_id`/`int_vector` are valid after edge m and held until the next accepted ack.
  - The pending bit is clear after edge m.
- Return: `int_ret` at edge r puts the state in IDLE after edge r. If `eligible != 0`, `irq` is high again after edge r+1.
- Mask change: deasserting `confINT[15]` while in REQ drops `irq` one edge later. Pending bits are preserved.
- Reset mid-operation: `rst` at any edge forces every reset value after that edge, including during SERVICE. An ack or ret in the same cycle as reset is ignored.
- An `src` held high produces exactly one pending set; a new set requires a low-to-high transition.

## Test plan
- Single event:
  - Stimulus: `confINT`=16'h8004; pulse `src[2]` at edge 10.
  - Response: `irq` high after edge 11.
  - Stimulus: ack at edge 14.
  - Response: `int_id`=2, `int_vector`=16'h0018, `pending`=0, `irq` low, `in_service`=1.
  - Stimulus: ret.
  - Response: IDLE, `irq` stays low.
- Priority:
  - Stimulus: `confINT`=16'h80FF; raise `src[5]`, then `src[1]` while in REQ; ack.
  - Response: `int_id`=1.
  - Stimulus: ret.
  - Response: `irq` returns 2 edges later.
  - Stimulus: next ack.
  - Response: `int_id`=5.
- Masking:
  - Stimulus: `confINT`=16'h0003; pulse `src[0]`.
  - Response: `pending`=8'h01 and `irq` stays 0.
  - Stimulus: set `confINT`=16'h8003.
  - Response: `irq` high after 1 edge.
  - Stimulus: `clr_pend`=8'h01 before ack.
  - Response: `irq` drops and the state returns to IDLE.
- Set/clear collision:
  - Stimulus: `clr_pend[3]` in the same cycle as a `src[3]` rising edge.
  - Response: `pending[3]`=1.
  - Stimulus: spurious ack in REQ with `eligible`=0.
  - Response: `int_id` unchanged, state IDLE.
- No nesting:
  - Stimulus: events on `src[0]` and `src[7]` during SERVICE.
  - Response: `irq` stays 0 until `int_ret`. `pending`=8'h81 at the time of ret.
- Reset in SERVICE:
  - Stimulus: assert `rst` for 1 cycle while in SERVICE.
  - Response: all outputs return to their reset values, including `int_vector`=16'h0010.
  - Stimulus: `src[4]` held high through reset.
  - Response: `pending[4]` set 1 edge after reset releases.
